// File: rtl/opera_bus_pkg.sv
// Shared types and constants for the opera Wishbone bus fabric.
package opera_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] ERR_READ_DATA   = 32'hFFFFFFFF;
   localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/opera_addr_decode.sv
// Combinational priority address decoder: lowest matching slave index wins,
// slave 0 is selected when no region matches.
module opera_addr_decode
   import opera_bus_pkg::*;
#(
   parameter int                       NUM_SLAVES  = 4,
   parameter logic [NUM_SLAVES*32-1:0] REGION_BASE = {32'h03400000, 32'h03300000, 32'h03200000, 32'h0},
   parameter logic [NUM_SLAVES*32-1:0] REGION_MASK = {NUM_SLAVES{32'hFFFF0000}},
   localparam int                      IDX_W       = $clog2(NUM_SLAVES)
) (
   input  logic [31:0]           i_adr,
   output logic [IDX_W-1:0]      o_idx,
   output logic [NUM_SLAVES-1:0] o_match
);

   for (genvar gi = 1; gi < NUM_SLAVES; gi++) begin : g_match
      assign o_match[gi] = (i_adr & REGION_MASK[gi*32 +: 32]) ==
                           (REGION_BASE[gi*32 +: 32] & REGION_MASK[gi*32 +: 32]);
   end

   // Bit 0 flags the fallback, so the vector always has at least one bit set.
   assign o_match[0] = ~|o_match[NUM_SLAVES-1:1];

   always_comb begin
      o_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 1; i--) begin
         if (o_match[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/opera_bus_fabric.sv
// Single-master Wishbone fabric with timeout handling.
// Optional debug counters are enabled by defining BUS_FABRIC_DEBUG_EN.
module opera_bus_fabric
   import opera_bus_pkg::*;
#(
   parameter int                       NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*32-1:0] REGION_BASE    = {32'h03400000, 32'h03300000, 32'h03200000, 32'h0},
   parameter logic [NUM_SLAVES*32-1:0] REGION_MASK    = {NUM_SLAVES{32'hFFFF0000}},
   parameter int                       TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                         sys_clk,
   input  logic                         reset_n,
   input  logic [31:0]                  m_adr,
   input  logic [31:0]                  m_dat_w,
   input  logic [3:0]                   m_sel,
   input  logic                         m_we,
   input  logic                         m_cyc,
   input  logic                         m_stb,
   output logic [31:0]                  m_dat_r,
   output logic                         m_ack,
   output logic                         m_err,
   output logic [31:0]                  s_adr,
   output logic [31:0]                  s_dat_w,
   output logic [3:0]                   s_sel,
   output logic                         s_we,
   output logic [NUM_SLAVES-1:0]        s_cyc,
   output logic [NUM_SLAVES-1:0]        s_stb,
   input  logic [NUM_SLAVES*32-1:0]     s_dat_r,
   input  logic [NUM_SLAVES-1:0]        s_ack,
   output logic [15:0]                  dbg_txn_cnt,
   output logic [31:0]                  dbg_err_adr
);

   localparam int IDX_W = $clog2(NUM_SLAVES);

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [15:0]           r_wait_cnt;
   logic [31:0]           r_s_adr;
   logic [31:0]           r_s_dat_w;
   logic [3:0]            r_s_sel;
   logic                  r_s_we;
   logic [NUM_SLAVES-1:0] r_s_strb;
   logic [31:0]           r_m_dat_r;
   logic                  r_m_ack;
   logic                  r_m_err;

   logic [IDX_W-1:0]      w_idx;
   logic [NUM_SLAVES-1:0] w_match;
   logic [NUM_SLAVES-1:0] w_onehot;
   logic [31:0]           w_rdata;
   logic                  w_ack_sel;
   logic                  w_active;
   logic                  w_err_evt;

   opera_addr_decode #(
      .NUM_SLAVES  (NUM_SLAVES),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK)
   ) u_decode (
      .i_adr   (m_adr),
      .o_idx   (w_idx),
      .o_match (w_match)
   );

   // Isolating the lowest set match bit gives the same winner as w_idx, already one-hot.
   assign w_onehot  = w_match & (~w_match + NUM_SLAVES'(1));
   assign w_ack_sel = |(s_ack & r_s_strb);
   assign w_active  = (r_state == ACTIVE) && m_cyc;
   assign w_err_evt = w_active && !w_ack_sel && (r_wait_cnt == 16'(TIMEOUT_CYCLES));

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == IDX_W'(i)) w_rdata = s_dat_r[i*32 +: 32];
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_wait_cnt <= '0;
         r_s_adr    <= '0;
         r_s_dat_w  <= '0;
         r_s_sel    <= '0;
         r_s_we     <= 1'b0;
         r_s_strb   <= '0;
         r_m_dat_r  <= '0;
         r_m_ack    <= 1'b0;
         r_m_err    <= 1'b0;
      end else begin
         r_m_ack <= 1'b0;
         r_m_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (m_cyc && m_stb) begin
                  r_s_adr    <= m_adr;
                  r_s_dat_w  <= m_dat_w;
                  r_s_sel    <= m_sel;
                  r_s_we     <= m_we;
                  r_idx      <= w_idx;
                  r_s_strb   <= w_onehot;
                  r_wait_cnt <= '0;
                  r_state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (!m_cyc) begin
                  r_s_strb <= '0;
                  r_state  <= IDLE;
               end else if (w_ack_sel) begin
                  r_m_dat_r <= w_rdata;
                  r_s_strb  <= '0;
                  r_m_ack   <= 1'b1;
                  r_state   <= RESP;
               end else if (w_err_evt) begin
                  r_m_dat_r <= ERR_READ_DATA;
                  r_s_strb  <= '0;
                  r_m_err   <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_s_strb <= '0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

`ifdef BUS_FABRIC_DEBUG_EN
   logic [15:0] r_dbg_txn_cnt;
   logic [31:0] r_dbg_err_adr;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dbg_txn_cnt <= '0;
         r_dbg_err_adr <= '0;
      end else begin
         if (r_m_ack || r_m_err) r_dbg_txn_cnt <= r_dbg_txn_cnt + 16'd1;
         if (w_err_evt)          r_dbg_err_adr <= r_s_adr;
      end
   end

   assign dbg_txn_cnt = r_dbg_txn_cnt;
   assign dbg_err_adr = r_dbg_err_adr;
`else
   assign dbg_txn_cnt = '0;
   assign dbg_err_adr = '0;
`endif

   assign m_dat_r = r_m_dat_r;
   assign m_ack   = r_m_ack;
   assign m_err   = r_m_err;
   assign s_adr   = r_s_adr;
   assign s_dat_w = r_s_dat_w;
   assign s_sel   = r_s_sel;
   assign s_we    = r_s_we;
   assign s_cyc   = r_s_strb;
   assign s_stb   = r_s_strb;

endmodule

// File: tb/tb_opera_bus_fabric.sv
// Self-checking bench for opera_bus_fabric: directed corner cases plus
// randomized transactions against a transaction-level reference model.
module tb_opera_bus_fabric;

   localparam int                 NS  = 4;
   localparam int                 TMO = 4;
   localparam logic [NS*32-1:0]   BASE_P = {32'h03400000, 32'h03300000, 32'h03200000, 32'h0};
   localparam logic [NS*32-1:0]   MASK_P = {NS{32'hFFFF0000}};
   localparam logic [31:0]        ERR_WORD = 32'hFFFFFFFF;

   logic              sysClk;
   logic              resetN;
   logic [31:0]       mAdr;
   logic [31:0]       mDatW;
   logic [3:0]        mSel;
   logic              mWe;
   logic              mCyc;
   logic              mStb;
   logic [31:0]       mDatR;
   logic              mAck;
   logic              mErr;
   logic [31:0]       sAdr;
   logic [31:0]       sDatW;
   logic [3:0]        sSel;
   logic              sWe;
   logic [NS-1:0]     sCyc;
   logic [NS-1:0]     sStb;
   logic [NS*32-1:0]  sDatR;
   logic [NS-1:0]     sAck;
   logic [15:0]       dbgTxnCnt;
   logic [31:0]       dbgErrAdr;

   int                checkCount;
   int                errorCount;
   logic [31:0]       lastRdata;
   logic [15:0]       expTxn;
   logic [31:0]       expErrAdr;

   opera_bus_fabric #(
      .NUM_SLAVES     (NS),
      .REGION_BASE    (BASE_P),
      .REGION_MASK    (MASK_P),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .sys_clk     (sysClk),
      .reset_n     (resetN),
      .m_adr       (mAdr),
      .m_dat_w     (mDatW),
      .m_sel       (mSel),
      .m_we        (mWe),
      .m_cyc       (mCyc),
      .m_stb       (mStb),
      .m_dat_r     (mDatR),
      .m_ack       (mAck),
      .m_err       (mErr),
      .s_adr       (sAdr),
      .s_dat_w     (sDatW),
      .s_sel       (sSel),
      .s_we        (sWe),
      .s_cyc       (sCyc),
      .s_stb       (sStb),
      .s_dat_r     (sDatR),
      .s_ack       (sAck),
      .dbg_txn_cnt (dbgTxnCnt),
      .dbg_err_adr (dbgErrAdr)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Region rule: lowest index i>=1 whose masked base equals the masked address, else 0.
   function automatic int expSlave(input logic [31:0] adr);
      for (int i = 1; i < NS; i++) begin
         if ((adr & MASK_P[i*32 +: 32]) == (BASE_P[i*32 +: 32] & MASK_P[i*32 +: 32])) return i;
      end
      return 0;
   endfunction

   task automatic checkDebug();
`ifdef BUS_FABRIC_DEBUG_EN
      checkOutput("dbg_txn", 32'(dbgTxnCnt), 32'(expTxn));
      checkOutput("dbg_err_adr", dbgErrAdr, expErrAdr);
`else
      checkOutput("dbg_txn", 32'(dbgTxnCnt), 32'd0);
      checkOutput("dbg_err_adr", dbgErrAdr, 32'd0);
`endif
   endtask

   task automatic randomSlaveData();
      for (int i = 0; i < NS; i++) sDatR[i*32 +: 32] = $urandom;
   endtask

   // One complete transaction; ackAt is the ACTIVE cycle (1-based) in which the
   // target slave acks, anything outside 1..TMO+1 means it never acks in time.
   task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                                input logic [3:0] sel, input logic [31:0] rdat, input int ackAt);
      int           slv;
      int           respCycle;
      logic [NS-1:0] oh;
      logic         expErr;
      slv       = expSlave(adr);
      oh        = NS'(1) << slv;
      expErr    = !(ackAt >= 1 && ackAt <= TMO + 1);
      respCycle = expErr ? TMO + 2 : ackAt + 1;
      mAdr  = adr;
      mWe   = we;
      mDatW = wdat;
      mSel  = sel;
      mCyc  = 1'b1;
      mStb  = 1'b1;
      sAck  = NS'($urandom);
      randomSlaveData();
      for (int c = 1; c <= respCycle; c++) begin
         @(posedge sysClk);
         @(negedge sysClk);
         if (c < respCycle) begin
            checkOutput("stb", 32'(sStb), 32'(oh));
            checkOutput("cyc", 32'(sCyc), 32'(oh));
            checkOutput("resp_early", 32'({mAck, mErr}), 32'd0);
            if (c == 1) begin
               checkOutput("s_adr", sAdr, adr);
               checkOutput("s_we", 32'(sWe), 32'(we));
               checkOutput("s_dat_w", sDatW, wdat);
               checkOutput("s_sel", 32'(sSel), 32'(sel));
            end
            randomSlaveData();
            sAck = NS'($urandom) & ~oh;
            if (c == ackAt) begin
               sAck = sAck | oh;
               sDatR[slv*32 +: 32] = rdat;
            end
         end else begin
            checkOutput("resp", 32'({mAck, mErr}), expErr ? 32'd1 : 32'd2);
            checkOutput("m_dat_r", mDatR, expErr ? ERR_WORD : rdat);
            checkOutput("stb_off", 32'(sStb), 32'd0);
            mCyc = 1'b0;
            mStb = 1'b0;
            sAck = NS'($urandom);
         end
      end
      lastRdata = expErr ? ERR_WORD : rdat;
      expTxn    = expTxn + 16'd1;
      if (expErr) expErrAdr = adr;
      @(posedge sysClk);
      @(negedge sysClk);
      checkOutput("pulse", 32'({mAck, mErr}), 32'd0);
      checkOutput("hold", mDatR, lastRdata);
      checkDebug();
   endtask

   task automatic applyAbort(input logic [31:0] adr);
      logic [NS-1:0] oh;
      oh    = NS'(1) << expSlave(adr);
      mAdr  = adr;
      mWe   = 1'b0;
      mCyc  = 1'b1;
      mStb  = 1'b1;
      sAck  = '0;
      for (int c = 1; c <= 2; c++) begin
         @(posedge sysClk);
         @(negedge sysClk);
         checkOutput("abort_stb", 32'(sStb), 32'(oh));
      end
      mCyc = 1'b0;
      mStb = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge sysClk);
         @(negedge sysClk);
         checkOutput("abort_stb_off", 32'(sStb), 32'd0);
         checkOutput("abort_resp", 32'({mAck, mErr}), 32'd0);
         checkOutput("abort_hold", mDatR, lastRdata);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_stb"}, 32'(sStb), 32'd0);
      checkOutput({tag, "_cyc"}, 32'(sCyc), 32'd0);
      checkOutput({tag, "_resp"}, 32'({mAck, mErr}), 32'd0);
      checkOutput({tag, "_m_dat_r"}, mDatR, 32'd0);
      checkOutput({tag, "_s_adr"}, sAdr, 32'd0);
      checkOutput({tag, "_s_dat_w"}, sDatW, 32'd0);
      checkOutput({tag, "_s_sel_we"}, 32'({sSel, sWe}), 32'd0);
      checkOutput({tag, "_dbg_txn"}, 32'(dbgTxnCnt), 32'd0);
      checkOutput({tag, "_dbg_err"}, dbgErrAdr, 32'd0);
   endtask

   task automatic applyMidReset(input logic [31:0] adr);
      logic [NS-1:0] oh;
      oh    = NS'(1) << expSlave(adr);
      mAdr  = adr;
      mWe   = 1'b1;
      mDatW = 32'hDEADBEEF;
      mSel  = 4'hF;
      mCyc  = 1'b1;
      mStb  = 1'b1;
      sAck  = '0;
      @(posedge sysClk);
      @(negedge sysClk);
      checkOutput("pre_reset_stb", 32'(sStb), 32'(oh));
      #2 resetN = 1'b0;
      #1 checkResetValues("mid_reset");
      lastRdata = '0;
      expTxn    = '0;
      expErrAdr = '0;
      mCyc = 1'b0;
      mStb = 1'b0;
      sAck = oh;
      @(posedge sysClk);
      @(negedge sysClk);
      resetN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge sysClk);
         @(negedge sysClk);
         checkOutput("late_ack_resp", 32'({mAck, mErr}), 32'd0);
         checkOutput("late_ack_stb", 32'(sStb), 32'd0);
      end
      sAck = '0;
      checkDebug();
   endtask

   initial begin
      logic [31:0] adr;
      int          region;
      checkCount = 0;
      errorCount = 0;
      lastRdata  = '0;
      expTxn     = '0;
      expErrAdr  = '0;
      resetN = 1'b1;
      mAdr   = '0;
      mDatW  = '0;
      mSel   = '0;
      mWe    = 1'b0;
      mCyc   = 1'b0;
      mStb   = 1'b0;
      sAck   = '0;
      sDatR  = '0;
      #1 resetN = 1'b0;
      @(negedge sysClk);
      checkResetValues("reset");
      @(negedge sysClk);
      resetN = 1'b1;
      @(negedge sysClk);

      applyStimulus(32'h03300010, 1'b0, 32'h0, 4'hF, 32'h12345678, 1);
      applyStimulus(32'h00001000, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0BADF00D, 3);
      applyStimulus(32'h03400000, 1'b0, 32'h0, 4'hF, 32'h11111111, 0);
      applyStimulus(32'h03200004, 1'b0, 32'h0, 4'h3, 32'hCAFEF00D, TMO + 1);
      applyStimulus(32'h0340FFFC, 1'b0, 32'h0, 4'hF, 32'h22222222, TMO + 2);
      applyAbort(32'h03200020);
      applyStimulus(32'h03200020, 1'b0, 32'h0, 4'hF, 32'h55AA55AA, 2);

      for (int n = 0; n < 40; n++) begin
         region = $urandom_range(0, NS);
         if (region == NS) adr = $urandom;
         else              adr = BASE_P[region*32 +: 32] | {16'h0, 16'($urandom)};
         applyStimulus(adr, 1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, TMO + 3));
      end

      applyMidReset(32'h03300000);
      applyStimulus(32'h03300040, 1'b0, 32'h0, 4'hF, 32'h0F0F0F0F, 1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/opera_bus_fabric.md
OPERA_BUS_FABRIC -- requirements
Module: opera_bus_fabric

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of slave ports (2..16); slave 0 is the fallback target.
REQ-002 Parameter REGION_BASE, default {32'h03400000,32'h03300000,32'h03200000,32'h0}, packed NUM_SLAVES*32 base addresses; entry i belongs to slave i.
REQ-003 Parameter REGION_MASK, default {32'hFFFF0000 x4}, packed NUM_SLAVES*32 compare masks.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, maximum number of wait cycles for a slave ack (1..65535).
REQ-005 sys_clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 m_adr, m_dat_w / m_sel / m_we, m_cyc, m_stb  in  32/32/4/1/1/1  Wishbone master request.
REQ-008 m_dat_r / m_ack / m_err  out  32/1/1  master response.
REQ-009 s_adr / s_dat_w / s_sel / s_we  out  32/32/4/1  request signals shared by all slaves.
REQ-010 s_cyc, s_stb  out  NUM_SLAVES  per-slave one-hot strobes.
REQ-011 s_dat_r / s_ack  in  NUM_SLAVES*32 / NUM_SLAVES  per-slave response.
REQ-012 dbg_txn_cnt / dbg_err_adr  out  16/32  debug counters (see Configuration).

Function
REQ-013 Slave i (i>=1) matches when (m_adr & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i]); the lowest matching index wins; no match selects slave 0.
REQ-014 FSM states: IDLE, ACTIVE, RESP.
REQ-015 IDLE: when m_cyc&m_stb=1, latch adr/dat_w/sel/we into s_* registers, latch the decoded index, clear the wait counter, and enter ACTIVE.
REQ-016 ACTIVE: drive s_cyc/s_stb one-hot at the latched index; increment the wait counter each cycle.
REQ-017 ACTIVE with s_ack[idx]=1: capture s_dat_r[idx] into m_dat_r, deassert slave strobes, and enter RESP.
REQ-018 ACTIVE with wait counter == TIMEOUT_CYCLES and no ack: m_dat_r <= 32'hFFFFFFFF, set the error flag, and enter RESP.
REQ-019 If ack and timeout occur in the same cycle, the ack wins: no error, slave data is returned.
REQ-020 RESP: m_ack=1 (or m_err=1 on timeout, never both) for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-021 Minimum latency: request in IDLE at cycle 0 -> slave strobe in cycle 1 -> ack sampled in cycle 1 -> m_ack in cycle 2.
REQ-022 Master abort: m_cyc=0 during ACTIVE returns the FSM to IDLE next cycle with strobes low and no m_ack/m_err.
REQ-023 s_ack on non-selected slaves, or any s_ack outside ACTIVE, is ignored.
REQ-024 m_dat_r holds its last value outside RESP; m_ack and m_err are registered outputs.

Reset
REQ-025 reset_n low: state=IDLE; s_cyc, s_stb, m_ack, m_err, s_we = 0; s_adr, s_dat_w, m_dat_r = 0; s_sel=0; wait counter=0; debug registers=0.
REQ-026 Reset asserted mid-transaction aborts it immediately; no response is issued after release.

Configuration
REQ-027 Macro BUS_FABRIC_DEBUG_EN defined: dbg_txn_cnt increments (wrapping at 16 bits) on each m_ack or m_err, and dbg_err_adr latches s_adr on each timeout.
REQ-028 Macro BUS_FABRIC_DEBUG_EN undefined: dbg_txn_cnt and dbg_err_adr are tied to 0 and no debug flops exist.

Structure
REQ-029 Package opera_bus_pkg SHALL hold the FSM state encoding, the error read value 32'hFFFFFFFF, and the default timeout constant.
REQ-030 Sub-module opera_addr_decode SHALL be the combinational priority decoder (m_adr in, index plus match vector out), parametrised by NUM_SLAVES, REGION_BASE, and REGION_MASK.

Verification
REQ-031 Read 32'h03300010, slave 2 acks in its first ACTIVE cycle with data 32'h12345678 -> m_ack in cycle 2, m_dat_r=32'h12345678, only s_stb[2] is ever high.
REQ-032 Write 32'h00001000 (unmatched), data 32'hA5A5A5A5, sel 4'hF -> s_stb[0], s_we=1, s_dat_w=32'hA5A5A5A5; slave 0 ack after 3 cycles -> single m_ack.
REQ-033 TIMEOUT_CYCLES=4, read 32'h03400000 with no ack -> m_err one cycle after the counter reaches 4, m_dat_r=32'hFFFFFFFF, m_ack=0; with the debug macro defined, dbg_err_adr=32'h03400000.
REQ-034 Ack and timeout in the same cycle -> m_ack=1, m_err=0, slave data is returned.
REQ-035 m_cyc dropped in the second ACTIVE cycle -> IDLE, no m_ack/m_err; the next request is serviced normally.
REQ-036 reset_n pulsed low asynchronously during ACTIVE -> all outputs reach their reset values before the next clock edge; a late s_ack produces no response.
